pipe_ctrl: RTL and testbench

Hazard and exception controller for the five-stage Y86-64 pipeline. It generates the per-stage stall/bubble controls consumed by reg_F, reg_D, reg_E, reg_M and reg_W: F_stall, D_stall, D_bubble, E_bubble, M_bubble and W_stall. It holds a sticky RUN/DRAIN/HALTED state machine so the pipeline freezes cleanly after an exception. Optional performance counters can be compiled in.

---
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Hazard/exception controller for the five-stage Y86-64 pipeline: per-stage stall/bubble
// controls plus a sticky RUN/DRAIN/HALTED machine. Define PIPE_CTRL_PERF_EN for perf counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_stalls,
  output logic [CNT_W-1:0] perf_bubbles,
  output logic [CNT_W-1:0] perf_mispred
`endif
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [1:0] S_AOK    = 2'd0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state_p0;
  state_t state_nxt;

  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

  function automatic logic dst_hit(input logic [3:0] dst,
                                   input logic [3:0] src_a,
                                   input logic [3:0] src_b);
    return (dst != R_NONE) && ((dst == src_a) || (dst == src_b));
  endfunction

  logic load_use;
  logic mispred;
  logic ret_inflight;
  logic m_exc;
  logic w_exc;

  assign load_use     = is_load(E_icode) && dst_hit(E_dstM, d_srcA, d_srcB);
  assign mispred      = (E_icode == I_JXX) && !e_Cnd;
  assign ret_inflight = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign m_exc        = (m_stat != S_AOK);
  assign w_exc        = (W_stat != S_AOK);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_p0 <= ST_RUN;
    else     state_p0 <= state_nxt;
  end

  // Next state: an exception reaching W always wins over one still in M
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_RUN: begin
        if (w_exc)      state_nxt = ST_HALTED;
        else if (m_exc) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_exc) state_nxt = ST_HALTED;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Output decode; reset forces NOPs into every stage register
  always_comb begin
    F_stall  = load_use | ret_inflight;
    D_stall  = load_use;
    D_bubble = mispred | (!load_use & ret_inflight);
    E_bubble = mispred | load_use;
    M_bubble = m_exc | w_exc;
    W_stall  = w_exc;
    halted   = 1'b0;
    case (state_p0)
      ST_DRAIN: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
      end
      ST_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
        halted   = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b0;
      halted   = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic in_run;
  assign in_run = (state_p0 == ST_RUN);

  // Counters wrap freely; only the RUN-state events are attributed to hazards
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles  <= '0;
      perf_stalls  <= '0;
      perf_bubbles <= '0;
      perf_mispred <= '0;
    end else begin
      if (state_p0 != ST_HALTED)           perf_cycles  <= perf_cycles + 1'b1;
      if (F_stall && in_run)               perf_stalls  <= perf_stalls + 1'b1;
      if ((D_bubble || E_bubble) && in_run) perf_bubbles <= perf_bubbles + 1'b1;
      if (mispred && in_run)               perf_mispred <= perf_mispred + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; perf counter checks compile in with PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_Cnd;
  logic [1:0] m_stat, W_stat;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stalls, perf_bubbles, perf_mispred;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
    .perf_bubbles(perf_bubbles), .perf_mispred(perf_mispred)
`endif
  );

  // Control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted}
  function automatic logic [6:0] ctl();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
    e_Cnd = 1'b1; m_stat = 2'd0; W_stat = 2'd0;
  endtask

  // One rising edge, then settle past the falling edge before the next checks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    chk("rst_ctl", {25'd0, ctl()}, 32'b0011100);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_ctl", {25'd0, ctl()}, 32'b0000000);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_cyc_rst", perf_cycles, 32'd0);
`endif

    // Five-cycle window: load_use, idle, mispredict, idle, idle
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    chk("load_use", {25'd0, ctl()}, 32'b1101000);
    tick();
    idle(); #1;
    chk("load_use_done", {25'd0, ctl()}, 32'b0000000);
    tick();
    E_icode = 4'h7; e_Cnd = 1'b0; #1;
    chk("mispred", {25'd0, ctl()}, 32'b0011000);
    tick();
    idle(); E_icode = 4'h7; e_Cnd = 1'b1; #1;
    chk("jxx_taken", {25'd0, ctl()}, 32'b0000000);
    tick();
    idle(); #1;
    tick();
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, 32'd5);
    chk("perf_stalls", perf_stalls, 32'd1);
    chk("perf_bubbles", perf_bubbles, 32'd2);
    chk("perf_mispred", perf_mispred, 32'd1);
`endif

    // Load-use variants: POPQ via srcB hits, RNONE destination never does
    E_icode = 4'hB; E_dstM = 4'h6; d_srcB = 4'h6; #1;
    chk("popq_srcB", {25'd0, ctl()}, 32'b1101000);
    E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF; #1;
    chk("dst_rnone", {25'd0, ctl()}, 32'b0000000);
    E_icode = 4'h2; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    chk("not_load", {25'd0, ctl()}, 32'b0000000);
    idle(); tick();

    // RET walking through D, E, M
    D_icode = 4'h9; #1;
    chk("ret_D", {25'd0, ctl()}, 32'b1010000);
    tick();
    D_icode = 4'h1; E_icode = 4'h9; #1;
    chk("ret_E", {25'd0, ctl()}, 32'b1010000);
    tick();
    E_icode = 4'h1; M_icode = 4'h9; #1;
    chk("ret_M", {25'd0, ctl()}, 32'b1010000);
    tick();
    M_icode = 4'h1; #1;
    chk("ret_done", {25'd0, ctl()}, 32'b0000000);
    D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    chk("ret_load_use", {25'd0, ctl()}, 32'b1101000);
    idle(); tick();

    // Exception: M fault -> DRAIN -> W fault -> HALTED
    m_stat = 2'd2; #1;
    chk("m_exc_run", {25'd0, ctl()}, 32'b0000100);
    tick();
    m_stat = 2'd0; W_stat = 2'd2; #1;
    chk("drain_w_exc", {25'd0, ctl()}, 32'b1010110);
    tick();
    idle(); #1;
    chk("halted_entry", {25'd0, ctl()}, 32'b1100111);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halted_sticky", {25'd0, ctl()}, 32'b1100111);
    end

    // Reset out of HALTED
    rst = 1'b1; #1;
    chk("rst_in_halt", {25'd0, ctl()}, 32'b0011100);
    tick();
    rst = 1'b0; #1;
    chk("halt_recovered", {25'd0, ctl()}, 32'b0000000);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_cyc_clr", perf_cycles, 32'd0);
    chk("perf_stl_clr", perf_stalls, 32'd0);
    chk("perf_bub_clr", perf_bubbles, 32'd0);
    chk("perf_mis_clr", perf_mispred, 32'd0);
`endif

    // DRAIN holds with clean inputs, then reset mid-DRAIN
    m_stat = 2'd3; tick();
    m_stat = 2'd0; #1;
    chk("drain_idle", {25'd0, ctl()}, 32'b1010000);
    tick();
    chk("drain_hold", {25'd0, ctl()}, 32'b1010000);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    chk("drain_recovered", {25'd0, ctl()}, 32'b0000000);

    // Simultaneous M and W faults go straight to HALTED
    m_stat = 2'd1; W_stat = 2'd1; #1;
    chk("both_exc_run", {25'd0, ctl()}, 32'b0000110);
    tick();
    idle(); #1;
    chk("direct_halt", {25'd0, ctl()}, 32'b1100111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
